adc_ch567_sampler: RTL and testbench
====================================

Name: adc_ch567_sampler

Overview:
- Serial-interface master for a 12-bit, 8-channel SPI-style ADC (ADC128S022-type protocol).
- Generates SCK from the 50 MHz system clock and drives channel addresses 5, 6, 7 round-robin on DIN.
- Shifts conversion results in from DOUT and holds the latest result for each of the three channels in a dedicated register.
- Sits between the board ADC pins and the sensor-processing logic.

Parameters:
- HALF_DIV, 10: clk_50 edges per SCK half-period (SCK = 2.5 MHz).
- FRAME_BITS, 16: SCK cycles per conversion frame.

Ports:
- clk_50 input 1: system clock, 50 MHz, rising edge.
- rst_n input 1: asynchronous active-low reset.
- dout input 1: ADC serial data out, MSB first.
- adc_cs_n output 1: ADC chip select, active low.
- din output 1: ADC serial data in, carries the address.
- adc_sck output 1: ADC serial clock.
- d_out_ch5 output 12: latest channel 5 result.
- d_out_ch6 output 12: latest channel 6 result.
- d_out_ch7 output 12: latest channel 7 result.
- data_frame output 2: index of the frame in progress. 0 = ch5 addressed, 1 = ch6, 2 = ch7.

Behaviour:
- Reset values:
  - adc_cs_n=1, adc_sck=0, din=0.
  - All d_out_ch* = 0, data_frame = 0.
  - Divider counter = HALF_DIV, bit counter = 0.
- Chip select: adc_cs_n goes to 0 on the first clock after reset release and stays low. Conversion is continuous; there is no gap between frames.
- SCK divider:
  - Counter decrements on every clk_50 edge.
  - At 0 it reloads HALF_DIV-1 and adc_sck toggles.
  - First SCK rise occurs on the 11th clock after reset release; thereafter SCK toggles every 10 clocks.
  - The first SCK high phase is a lead-in. The following falling edge starts frame 0, cycle 0.
- Cycle timing:
  - A cycle runs from one SCK falling edge to the next. Cycles are numbered 0..15 and wrap.
  - data_frame advances 0→1→2→0 at the falling edge that starts cycle 0. Frame 0 has data_frame=0.
- DIN:
  - Updated on the same clock that drives SCK low at the start of each cycle.
  - In cycles 2, 3, 4 it carries ADD2, ADD1, ADD0 of the channel addressed by data_frame: 5 = 101, 6 = 110, 7 = 111.
  - It is 0 in all other cycles and during the lead-in.
- DOUT capture:
  - Sample dout on the clock that drives SCK high, during cycles 4..14.
  - Shift into result bits 11..1, MSB first.
  - Result bit 0 is always 0. The cycle-15 bit is not used.
- Result load:
  - On the last clk_50 edge of cycle 14 (the edge before SCK falls into cycle 15), load the 12-bit result into one channel register.
  - Data received in a frame belongs to the previously addressed channel:
    - data_frame=0 loads d_out_ch7.
    - data_frame=1 loads d_out_ch5.
    - data_frame=2 loads d_out_ch6.
  - Frame 0 after reset loads ch7.
  - The other two registers hold their values.
- Load timing: first loads land at 6.4 µs (ch7), 12.8 µs (ch5) and 19.2 µs (ch6) after reset release, i.e. 16 SCK periods apart.
- Reset mid-frame: asynchronous return to reset values. A new lead-in starts on release. Partial shift data is discarded.

Optional Feature:
- Macro: ADC_DATA_VALID_EN.
- When defined, adds an output data_valid (1 bit, reset 0). It pulses high for exactly one clk_50 cycle, coincident with each channel-register load.
- When undefined, the port is absent and behaviour is otherwise identical.

Decomposition:
- Shared package adc_ch567_pkg holds:
  - HALF_DIV and FRAME_BITS.
  - Channel address constants ADDR_CH5/6/7 (3'b101/110/111).
  - A 2-bit frame-index type with values FR_CH5=0, FR_CH6=1, FR_CH7=2.
- One sub-module is natural: adc_sck_gen, the divider plus cycle counter. It outputs adc_sck, rise/fall strobes, the cycle number and a "last edge before fall" strobe.
- The shift register and channel demux stay in the top level.

Test Plan:
- SCK and CS timing: reset, then free-run. Required response:
  - adc_sck rises at clock 11 and toggles every 10 clocks (period 400 ns).
  - adc_cs_n goes low one clock after reset release.
- Address sequence: capture din per cycle. Required response:
  - Cycles 2-4 read 101 in frame 0, 110 in frame 1, 111 in frame 2, 101 again in frame 3.
  - All other din cycles are 0.
- Frame-0 capture: drive DOUT bits for cycles 4..15 = 1110 1101 1010. Required response:
  - d_out_ch7 becomes 3802 at the last edge of cycle 14 (6.4 µs).
  - ch5 and ch6 remain 0.
- Frames 1 and 2: drive DOUT 0100 0101 1110 in frame 1 and 0111 1100 1110 in frame 2. Required response:
  - d_out_ch5 = 1118 at 12.8 µs.
  - d_out_ch6 = 1998 at 19.2 µs.
  - d_out_ch7 holds 3802.
- LSB and ignore rules: drive DOUT=1 in cycles 0-3 and 15. Required response: results unchanged from the previous cases and bit 0 always reads 0.
- Reset mid-frame: assert rst_n during frame 1, cycle 8. Required response:
  - All outputs return to 0 immediately.
  - After release, the lead-in repeats and the first load goes to ch7.

Source files
------------

// File: rtl/adc_ch567_pkg.sv
// Shared constants and types for the ch5/6/7 ADC sampler.
// Build option: ADC_DATA_VALID_EN adds a load-strobe output.
package adc_ch567_pkg;

  localparam int unsigned HALF_DIV   = 10;
  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned CNT_W      = $clog2(HALF_DIV + 1);
  localparam int unsigned CYC_W      = $clog2(FRAME_BITS);

  localparam logic [2:0] ADDR_CH5 = 3'b101;
  localparam logic [2:0] ADDR_CH6 = 3'b110;
  localparam logic [2:0] ADDR_CH7 = 3'b111;

  typedef enum logic [1:0] {
    FR_CH5 = 2'd0,
    FR_CH6 = 2'd1,
    FR_CH7 = 2'd2
  } frame_e;

  function automatic logic [2:0] addr_of(frame_e f);
    logic [2:0] a;
    case (f)
      FR_CH6:  a = ADDR_CH6;
      FR_CH7:  a = ADDR_CH7;
      default: a = ADDR_CH5;
    endcase
    return a;
  endfunction

  function automatic frame_e frame_next(frame_e f);
    frame_e n;
    case (f)
      FR_CH5:  n = FR_CH6;
      FR_CH6:  n = FR_CH7;
      default: n = FR_CH5;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/adc_ch567_sampler_sck_gen.sv
// SCK divider and cycle counter for the ADC serial frame.
// First high phase after reset is a lead-in with no cycle count.
module adc_sck_gen
  import adc_ch567_pkg::*;
(
  input  logic             clk_50,
  input  logic             rst_n,
  output logic             adc_sck,
  output logic             rise,
  output logic             fall,
  output logic             pre_fall,
  output logic             lead,
  output logic [CYC_W-1:0] cycle
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic             sck_q, sck_d;
  logic             lead_q, lead_d;
  logic             tick;

  always_comb begin
    tick   = (cnt_q == '0);
    cnt_d  = tick ? CNT_W'(HALF_DIV - 1) : cnt_q - 1'b1;
    sck_d  = sck_q ^ tick;
    lead_d = lead_q;
    cyc_d  = cyc_q;
    if (tick && sck_q) begin
      if (lead_q) begin
        lead_d = 1'b0;
      end else if (cyc_q == CYC_W'(FRAME_BITS - 1)) begin
        cyc_d = '0;
      end else begin
        cyc_d = cyc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= CNT_W'(HALF_DIV);
      cyc_q  <= '0;
      sck_q  <= 1'b0;
      lead_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      cyc_q  <= cyc_d;
      sck_q  <= sck_d;
      lead_q <= lead_d;
    end
  end

  assign adc_sck  = sck_q;
  assign rise     = tick & ~sck_q;
  assign fall     = tick & sck_q;
  assign pre_fall = sck_q & (cnt_q == CNT_W'(1));
  assign lead     = lead_q;
  assign cycle    = cyc_q;

endmodule

// File: rtl/adc_ch567_sampler.sv
// Round-robin ch5/6/7 master for an ADC128S022-style serial ADC.
// Define ADC_DATA_VALID_EN to add the data_valid load strobe.
module adc_ch567_sampler
  import adc_ch567_pkg::*;
(
  input  logic        clk_50,
  input  logic        rst_n,
  input  logic        dout,
  output logic        adc_cs_n,
  output logic        din,
  output logic        adc_sck,
  output logic [11:0] d_out_ch5,
  output logic [11:0] d_out_ch6,
  output logic [11:0] d_out_ch7,
  output logic [1:0]  data_frame
`ifdef ADC_DATA_VALID_EN
  ,
  output logic        data_valid
`endif
);

  logic             rise, fall, pre_fall, lead;
  logic [CYC_W-1:0] cycle, nc;

  logic        cs_q, cs_d;
  logic        din_q, din_d;
  logic [10:0] sh_q, sh_d;
  logic [11:0] ch5_q, ch5_d;
  logic [11:0] ch6_q, ch6_d;
  logic [11:0] ch7_q, ch7_d;
  frame_e      frame_q, frame_d;
  logic [2:0]  addr;
  logic        load;

  adc_sck_gen u_sck (
    .clk_50   (clk_50),
    .rst_n    (rst_n),
    .adc_sck  (adc_sck),
    .rise     (rise),
    .fall     (fall),
    .pre_fall (pre_fall),
    .lead     (lead),
    .cycle    (cycle)
  );

  always_comb begin
    cs_d    = 1'b0;
    din_d   = din_q;
    sh_d    = sh_q;
    ch5_d   = ch5_q;
    ch6_d   = ch6_q;
    ch7_d   = ch7_q;
    frame_d = frame_q;
    nc      = '0;
    if (!lead && cycle != CYC_W'(FRAME_BITS - 1)) begin
      nc = cycle + 1'b1;
    end
    if (fall && !lead && nc == '0) begin
      frame_d = frame_next(frame_q);
    end
    addr = addr_of(frame_d);
    // DIN follows the cycle/frame that this falling edge starts
    if (fall) begin
      case (nc)
        CYC_W'(2): din_d = addr[2];
        CYC_W'(3): din_d = addr[1];
        CYC_W'(4): din_d = addr[0];
        default:   din_d = 1'b0;
      endcase
    end
    if (rise && !lead && cycle >= CYC_W'(4) && cycle <= CYC_W'(14)) begin
      sh_d = {sh_q[9:0], dout};
    end
    load = pre_fall && !lead && cycle == CYC_W'(14);
    // Data in this frame answers the address sent one frame earlier
    if (load) begin
      unique case (1'b1)
        (frame_q == FR_CH5): ch7_d = {sh_q, 1'b0};
        (frame_q == FR_CH6): ch5_d = {sh_q, 1'b0};
        (frame_q == FR_CH7): ch6_d = {sh_q, 1'b0};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      cs_q    <= 1'b1;
      din_q   <= 1'b0;
      sh_q    <= '0;
      ch5_q   <= '0;
      ch6_q   <= '0;
      ch7_q   <= '0;
      frame_q <= FR_CH5;
    end else begin
      cs_q    <= cs_d;
      din_q   <= din_d;
      sh_q    <= sh_d;
      ch5_q   <= ch5_d;
      ch6_q   <= ch6_d;
      ch7_q   <= ch7_d;
      frame_q <= frame_d;
    end
  end

`ifdef ADC_DATA_VALID_EN
  logic valid_q, valid_d;

  always_comb begin
    valid_d = load;
  end

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
  end

  assign data_valid = valid_q;
`endif

  assign adc_cs_n   = cs_q;
  assign din        = din_q;
  assign d_out_ch5  = ch5_q;
  assign d_out_ch6  = ch6_q;
  assign d_out_ch7  = ch7_q;
  assign data_frame = frame_q;

endmodule

// File: tb/tb_adc_ch567_sampler.sv
// Directed bench for adc_ch567_sampler: SCK/CS timing, address
// sequence, channel loads and mid-frame reset.
module tb_adc_ch567_sampler;

  logic        clk;
  logic        rst_n;
  logic        dout;
  logic        adc_cs_n;
  logic        din;
  logic        adc_sck;
  logic [11:0] d_out_ch5;
  logic [11:0] d_out_ch6;
  logic [11:0] d_out_ch7;
  logic [1:0]  data_frame;
`ifdef ADC_DATA_VALID_EN
  logic        data_valid;
`endif

  int tests;
  int fails;
  int clk_n;

  logic [11:0] cur5, cur6, cur7;
  logic [15:0] pats [0:4];

  adc_ch567_sampler dut (
    .clk_50     (clk),
    .rst_n      (rst_n),
    .dout       (dout),
    .adc_cs_n   (adc_cs_n),
    .din        (din),
    .adc_sck    (adc_sck),
    .d_out_ch5  (d_out_ch5),
    .d_out_ch6  (d_out_ch6),
    .d_out_ch7  (d_out_ch7),
    .data_frame (data_frame)
`ifdef ADC_DATA_VALID_EN
    ,
    .data_valid (data_valid)
`endif
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d at clk %0d",
             tag, obs, exp, clk_n);
    end
  endtask

  task automatic goto(input int k);
    while (clk_n < k) begin
      @(posedge clk);
      clk_n++;
    end
    #1;
  endtask

  function automatic logic exp_din(input int fr, input int c);
    logic [2:0] a;
    case (fr)
      0:       a = 3'b101;
      1:       a = 3'b110;
      default: a = 3'b111;
    endcase
    if (c >= 2 && c <= 4) return a[4 - c];
    return 1'b0;
  endfunction

  task automatic chk_regs(input string tag);
    chk({tag, "_ch5"}, d_out_ch5, cur5);
    chk({tag, "_ch6"}, d_out_ch6, cur6);
    chk({tag, "_ch7"}, d_out_ch7, cur7);
  endtask

  task automatic do_cycle(input int g, input logic [15:0] p);
    int f, c, ld;
    f = g / 16;
    c = g % 16;
    goto(21 + 20 * g);
    dout = p[15 - c];
    chk("sck_lo", adc_sck, 0);
    chk("cs_low", adc_cs_n, 0);
    chk("din", din, exp_din(f % 3, c));
    chk("frame", data_frame, f % 3);
    goto(31 + 20 * g);
    chk("sck_hi", adc_sck, 1);
    if (c == 14) begin
      ld = 320 + 320 * f;
      goto(ld - 1);
      chk_regs("preload");
      case (f % 3)
        0:       cur7 = {p[11:1], 1'b0};
        1:       cur5 = {p[11:1], 1'b0};
        default: cur6 = {p[11:1], 1'b0};
      endcase
      goto(ld);
      chk_regs("load");
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_cs"}, adc_cs_n, 1);
    chk({tag, "_sck"}, adc_sck, 0);
    chk({tag, "_din"}, din, 0);
    chk({tag, "_ch5"}, d_out_ch5, 0);
    chk({tag, "_ch6"}, d_out_ch6, 0);
    chk({tag, "_ch7"}, d_out_ch7, 0);
    chk({tag, "_frame"}, data_frame, 0);
  endtask

  task automatic chk_lead();
    chk("cs_pre", adc_cs_n, 1);
    goto(1);
    chk("cs_first", adc_cs_n, 0);
    chk("sck_c1", adc_sck, 0);
    goto(10);
    chk("sck_c10", adc_sck, 0);
    goto(11);
    chk("sck_rise11", adc_sck, 1);
    chk("din_lead", din, 0);
    goto(20);
    chk("sck_c20", adc_sck, 1);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    clk_n = 0;
    rst_n = 1'b0;
    dout  = 1'b0;
    cur5  = '0;
    cur6  = '0;
    cur7  = '0;
    pats[0] = 16'h0EDA;
    pats[1] = 16'h045E;
    pats[2] = 16'h07CE;
    pats[3] = 16'hFEDB;
    pats[4] = 16'hFFFF;

    repeat (3) @(posedge clk);
    #1;
    chk_reset("rst");
    @(negedge clk);
    rst_n = 1'b1;
    clk_n = 0;
    #1;
    chk_lead();

    for (int g = 0; g <= 72; g++) begin
      do_cycle(g, pats[g / 16]);
      if (g == 63) begin
        chk("ch7_3802", d_out_ch7, 12'd3802);
        chk("ch5_1118", d_out_ch5, 12'd1118);
        chk("ch6_1998", d_out_ch6, 12'd1998);
        chk("ch7_lsb", d_out_ch7[0], 0);
      end
    end

    goto(21 + 20 * 72 + 5);
    rst_n = 1'b0;
    #2;
    chk_reset("midrst");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    clk_n = 0;
    cur5  = '0;
    cur6  = '0;
    cur7  = '0;
    #1;
    chk_lead();
    for (int g = 0; g < 16; g++) begin
      do_cycle(g, 16'h0AAA);
    end
    chk("rerun_ch7", d_out_ch7, 12'd2730);
    chk("rerun_ch5", d_out_ch5, 12'd0);
    chk("rerun_ch6", d_out_ch6, 12'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
